// File: rtl/tile_mon_pkg.sv
// Shared defaults and event layout for the tile output monitor.
// Latency and backpressure behaviour are described by the modules that import this package.
package tile_mon_pkg;

  localparam int TM_WIDTH    = 8;
  localparam int TM_TS_WIDTH = 8;

  typedef struct packed {
    logic [TM_TS_WIDTH-1:0] ts;
    logic [TM_WIDTH-1:0]    value;
  } tile_evt_t;

  // Occupancy counter width: one extra bit so that full and empty are distinguishable.
  function automatic int tm_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tile_evt_fifo.sv
// Register-array FIFO with no bypass; a push is visible at the head one edge later.
// When full, a push is accepted only alongside a pop; otherwise the caller sees full_o and drops the entry.
module tile_evt_fifo
  import tile_mon_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DW-1:0]                din_i,
  output logic [DW-1:0]                dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [tm_cnt_w(DEPTH)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = tm_cnt_w(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [CW-1:0] wr_q, wr_d;
  logic [CW-1:0] rd_q, rd_d;
  logic          wr_en, rd_en;

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Full plus pop frees the head slot on the same edge, so the write lands there.
  assign wr_en = push_i & (~full_o | pop_i);
  assign rd_en = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (wr_en) wr_d = wr_q + CW'(1);
    if (rd_en) rd_d = rd_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (wr_en) mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/tile_out_monitor.sv
// Synchronises a tile output bus and logs each change as {timestamp, value}; 3 edges from a stable input to evt_valid.
// The consumer stalls via evt_ready; changes arriving while the FIFO is full are dropped and flagged in sticky overflow.
module tile_out_monitor
  import tile_mon_pkg::*;
#(
  parameter int WIDTH    = TM_WIDTH,
  parameter int TS_WIDTH = TM_TS_WIDTH,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          tile_out,
  input  logic                      en,
  input  logic                      clr_ovf,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [TS_WIDTH+WIDTH-1:0] evt_data,
  output logic [$clog2(DEPTH):0]    evt_count,
  output logic                      overflow
);

  logic [WIDTH-1:0]    s1_q, s2_q, prev_q;
  logic [TS_WIDTH-1:0] ts_q;
  logic                ovf_q, ovf_d;
  logic                chg, push, pop, drop;
  logic                fifo_full, fifo_empty;

  // prev follows s2 unconditionally, so raising en never reports a stale difference.
  assign chg  = (s2_q != prev_q);
  assign push = chg & en;
  assign pop  = evt_valid & evt_ready;
  assign drop = push & fifo_full & ~pop;

  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      ts_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      s1_q   <= tile_out;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      ts_q   <= ts_q + TS_WIDTH'(1);
      ovf_q  <= ovf_d;
    end
  end

  tile_evt_fifo #(
    .DW    (TS_WIDTH + WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({ts_q, s2_q}),
    .dout_o  (evt_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (evt_count)
  );

  assign evt_valid = ~fifo_empty;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_tile_out_monitor.sv
// Bench for tile_out_monitor: directed scenarios plus random traffic against an edge-history reference model.
module tb_tile_out_monitor;
  import tile_mon_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  tile_out = 8'h00;
  logic        en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        evt_ready = 1'b0;
  logic        evt_valid;
  logic [15:0] evt_data;
  logic [2:0]  evt_count;
  logic        overflow;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tile_out_monitor #(.WIDTH(8), .TS_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tile_out  (tile_out),
    .en        (en),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  // Reference model: the input seen at edge j is hist[j-1]; an event is logged at edge e
  // when the value seen at edge e-2 differs from the one seen at edge e-3, stamped e-1.
  logic [7:0]  hist[$];
  logic [15:0] mq[$];
  bit          m_ovf;
  int          e;
  logic [7:0]  ma, mb;
  bit          mev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      mq.delete();
      m_ovf = 1'b0;
      e = 0;
    end else begin
      e++;
      hist.push_back(tile_out);
      ma = (e - 2 >= 1) ? hist[e-3] : 8'h00;
      mb = (e - 3 >= 1) ? hist[e-4] : 8'h00;
      mev = en && (ma != mb);
      if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
      if (mev && mq.size() >= DEPTH) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (mev && mq.size() < DEPTH) mq.push_back({8'(e - 1), ma});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tile_out = 8'h00; en = 1'b0; clr_ovf = 1'b0; evt_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", evt_valid); end
    n_cmp++; if (evt_data !== 16'h0) begin n_fail++; $display("FAIL rst_data got=%h exp=0000", evt_data); end
    n_cmp++; if (evt_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", evt_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    step(2);
    rst_n = 1'b1; en = 1'b1; tile_out = 8'h00;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++; if (evt_valid !== 1'b0 || evt_count !== 3'd0 || overflow !== 1'b0) begin
        n_fail++; $display("FAIL idle_quiet cyc=%0d got v=%b c=%0d o=%b exp v=0 c=0 o=0", i, evt_valid, evt_count, overflow);
      end
    end
  endtask

  task automatic test_first_event();
    tile_evt_t hd;
    do_reset();
    en = 1'b1; evt_ready = 1'b0;
    step(5);
    tile_out = 8'hA5;
    for (int i = 1; i <= 2; i++) begin
      step();
      n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early edge=%0d got=%b exp=0", i, evt_valid); end
    end
    step();
    n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL lat_third got=%b exp=1", evt_valid); end
    hd = tile_evt_t'(evt_data);
    n_cmp++; if (hd.ts !== 8'h07 || hd.value !== 8'hA5) begin
      n_fail++; $display("FAIL first_data got=%h exp=07a5", evt_data);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (evt_valid !== 1'b1 || evt_data !== 16'h07A5) begin
        n_fail++; $display("FAIL head_hold cyc=%0d got v=%b d=%h exp v=1 d=07a5", i, evt_valid, evt_data);
      end
    end
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    n_cmp++; if (evt_count !== 3'd0 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL first_drain got c=%0d v=%b exp c=0 v=0", evt_count, evt_valid);
    end
  endtask

  task automatic test_overflow();
    en = 1'b1; evt_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      tile_out = 8'(v);
      step(4);
    end
    n_cmp++; if (evt_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got=%0d exp=4", evt_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    evt_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      n_cmp++; if (evt_valid !== 1'b1 || evt_data[7:0] !== 8'(v)) begin
        n_fail++; $display("FAIL ovf_drain idx=%0d got v=%b val=%h exp v=1 val=%h", v, evt_valid, evt_data[7:0], 8'(v));
      end
      n_cmp++; if (mq.size() == 0 || evt_data !== mq[0]) begin
        n_fail++; $display("FAIL ovf_drain_ts idx=%0d got=%h exp=%h", v, evt_data, (mq.size() > 0) ? mq[0] : 16'hxxxx);
      end
      step();
    end
    evt_ready = 1'b0;
    n_cmp++; if (evt_count !== 3'd0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky got c=%0d o=%b exp c=0 o=1", evt_count, overflow);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    en = 1'b1; evt_ready = 1'b0;
    for (int v = 8'h41; v <= 8'h44; v++) begin
      tile_out = 8'(v);
      step(4);
    end
    n_cmp++; if (evt_count !== 3'd4 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL fpp_fill got c=%0d o=%b exp c=4 o=0", evt_count, overflow);
    end
    tile_out = 8'h45;
    step(2);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    n_cmp++; if (evt_count !== 3'd4 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL fpp_same_edge got c=%0d o=%b exp c=4 o=0", evt_count, overflow);
    end
    evt_ready = 1'b1;
    for (int v = 8'h42; v <= 8'h45; v++) begin
      n_cmp++; if (evt_valid !== 1'b1 || evt_data[7:0] !== 8'(v)) begin
        n_fail++; $display("FAIL fpp_drain got v=%b val=%h exp v=1 val=%h", evt_valid, evt_data[7:0], 8'(v));
      end
      step();
    end
    evt_ready = 1'b0;
    n_cmp++; if (evt_count !== 3'd0) begin n_fail++; $display("FAIL fpp_empty got=%0d exp=0", evt_count); end
  endtask

  task automatic test_enable();
    en = 1'b0; evt_ready = 1'b0;
    tile_out = 8'h10; step(4);
    tile_out = 8'h20; step(4);
    en = 1'b1; step(6);
    n_cmp++; if (evt_count !== 3'd0 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL en_rise got c=%0d v=%b exp c=0 v=0", evt_count, evt_valid);
    end
    tile_out = 8'h30; step(4);
    n_cmp++; if (evt_count !== 3'd1 || evt_data[7:0] !== 8'h30) begin
      n_fail++; $display("FAIL en_one got c=%0d val=%h exp c=1 val=30", evt_count, evt_data[7:0]);
    end
    evt_ready = 1'b1; step(); evt_ready = 1'b0;
  endtask

  task automatic test_wrap_reset();
    do_reset();
    en = 1'b1; evt_ready = 1'b1;
    for (int k = 1; k <= 264; k++) begin
      step();
      n_cmp++; if (evt_valid !== (mq.size() > 0) || evt_count !== 3'(mq.size()) || overflow !== m_ovf) begin
        n_fail++; $display("FAIL wrap_state k=%0d got v=%b c=%0d o=%b exp c=%0d o=%b", k, evt_valid, evt_count, overflow, mq.size(), m_ovf);
      end
      if (mq.size() > 0) begin
        n_cmp++; if (evt_data !== mq[0]) begin n_fail++; $display("FAIL wrap_data k=%0d got=%h exp=%h", k, evt_data, mq[0]); end
      end
      if (k <= 236 && $urandom_range(0, 3) == 0) tile_out = 8'($urandom);
      if (k == 240) tile_out = 8'h5A;
      if (k == 250) evt_ready = 1'b0;
      if (k == 252) tile_out = 8'h11;
      if (k == 256) tile_out = 8'h22;
    end
    n_cmp++; if (evt_count !== 3'd2 || evt_data !== 16'hFE11) begin
      n_fail++; $display("FAIL wrap_pre got c=%0d d=%h exp c=2 d=fe11", evt_count, evt_data);
    end
    evt_ready = 1'b1; step(); evt_ready = 1'b0;
    n_cmp++; if (evt_data !== 16'h0222) begin n_fail++; $display("FAIL wrap_post got=%h exp=0222", evt_data); end
    tile_out = 8'h33; step(4);
    n_cmp++; if (evt_count !== 3'd2) begin n_fail++; $display("FAIL wrap_queued got=%0d exp=2", evt_count); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (evt_valid !== 1'b0 || evt_count !== 3'd0 || evt_data !== 16'h0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL midrst got v=%b c=%0d d=%h o=%b exp all 0", evt_valid, evt_count, evt_data, overflow);
    end
    step();
    rst_n = 1'b1;
    step(2);
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rel_early got=%b exp=0", evt_valid); end
    step();
    n_cmp++; if (evt_count !== 3'd1 || evt_data !== 16'h0233) begin
      n_fail++; $display("FAIL rel_event got c=%0d d=%h exp c=1 d=0233", evt_count, evt_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      step();
      n_cmp++; if (evt_valid !== (mq.size() > 0) || evt_count !== 3'(mq.size()) || overflow !== m_ovf) begin
        n_fail++; $display("FAIL rnd_state k=%0d got v=%b c=%0d o=%b exp c=%0d o=%b", k, evt_valid, evt_count, overflow, mq.size(), m_ovf);
      end
      if (mq.size() > 0) begin
        n_cmp++; if (evt_data !== mq[0]) begin n_fail++; $display("FAIL rnd_data k=%0d got=%h exp=%h", k, evt_data, mq[0]); end
      end
      en        = ($urandom_range(0, 9) != 0);
      evt_ready = ($urandom_range(0, 2) == 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 0) tile_out = 8'($urandom);
    end
    en = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_event();
    test_overflow();
    test_full_push_pop();
    test_enable();
    test_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
